// File: rtl/hazard_issue_ctrl.sv
// Issue-stage hazard controller: stalls fetch and substitutes NOP bubbles for
// load-use, flag-dependency and control-flow-shadow hazards; counts stall cycles.
module hazard_issue_ctrl #(
  parameter int               ISIZE      = 16,
  parameter logic [3:0]       LOAD_OP    = 4'h8,
  parameter logic [3:0]       EXEC_OP    = 4'hC,
  parameter logic [ISIZE-1:0] NOP_INSTR  = 16'h7000,
  parameter int               LOAD_LAT   = 1,
  parameter int               BR_BUBBLES = 2,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ISIZE-1:0] instr_in,
  input  logic             instr_valid,
  input  logic             flush,
  output logic             pc_en,
  output logic             instr_sel,
  output logic [ISIZE-1:0] instr_out,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [3:0] op, rd, rs, rt;
  logic       is_ctrl, is_alu, is_load, is_exec;
  logic       use_rs, use_rt, use_rd;
  logic       load_use, issue;

  logic [LOAD_LAT-1:0] sb_v;
  logic [3:0]          sb_rd [LOAD_LAT];
  logic [2:0]          bub_cnt;
  logic                last_alu, exec_pend;

  assign op      = instr_in[15:12];
  assign rd      = instr_in[11:8];
  assign rs      = instr_in[7:4];
  assign rt      = instr_in[3:0];
  assign is_ctrl = (op[3:2] == 2'b11);
  assign is_alu  = (op[3:2] == 2'b00);
  assign is_load = (op == LOAD_OP);
  assign is_exec = (op == EXEC_OP);
  assign use_rs  = (op < 4'd10);
  assign use_rt  = (op < 4'd5);
  assign use_rd  = (op >= 4'd14);

  // Register 0 is hardwired, so a pending load to r0 never blocks a reader.
  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_v[i]) begin
        if (use_rs && rs != 4'd0 && rs == sb_rd[i]) load_use = 1'b1;
        if (use_rt && rt != 4'd0 && rt == sb_rd[i]) load_use = 1'b1;
        if (use_rd && rd != 4'd0 && rd == sb_rd[i]) load_use = 1'b1;
      end
    end
  end

  always_comb begin
    pc_en     = 1'b1;
    instr_sel = 1'b1;
    if (flush) begin
      pc_en = 1'b1;
    end else if (bub_cnt != 3'd0) begin
      pc_en = 1'b0;
    end else if (instr_valid && is_ctrl && last_alu && !exec_pend) begin
      pc_en = 1'b0;
    end else if (instr_valid && load_use) begin
      pc_en = 1'b0;
    end else if (instr_valid) begin
      instr_sel = 1'b0;
    end
  end

  assign issue     = !instr_sel;
  assign instr_out = instr_sel ? NOP_INSTR : instr_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_v      <= '0;
      for (int i = 0; i < LOAD_LAT; i++) sb_rd[i] <= 4'd0;
      bub_cnt   <= 3'd0;
      last_alu  <= 1'b0;
      exec_pend <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        sb_v      <= '0;
        bub_cnt   <= 3'd0;
        last_alu  <= 1'b0;
        exec_pend <= 1'b0;
      end else begin
        for (int i = LOAD_LAT - 1; i > 0; i--) begin
          sb_v[i]  <= sb_v[i-1];
          sb_rd[i] <= sb_rd[i-1];
        end
        sb_v[0]  <= issue && is_load;
        sb_rd[0] <= (issue && is_load) ? rd : 4'd0;
        // An EXEC'd control instruction runs without a shadow; EXEC itself never arms one.
        if (issue && is_ctrl && !is_exec && !exec_pend)
          bub_cnt <= 3'(BR_BUBBLES);
        else if (bub_cnt != 3'd0)
          bub_cnt <= bub_cnt - 3'd1;
        last_alu <= issue && is_alu;
        if (issue) exec_pend <= is_exec;
      end
      if (instr_sel && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Directed bench for hazard_issue_ctrl; four instances with different parameters
// share one stimulus stream, each check targets the instance it is about.
module tb_hazard_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr_in = 16'h0;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;

  logic        pc_en1, sel1, pc_en2, sel2, pc_en3, sel3, pc_en4, sel4;
  logic [15:0] out1, out2, out3, out4;
  logic [15:0] cnt1, cnt2, cnt4;
  logic [3:0]  cnt3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_issue_ctrl dut1 (.clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .flush(flush), .pc_en(pc_en1), .instr_sel(sel1), .instr_out(out1), .stall_cnt(cnt1));
  hazard_issue_ctrl #(.LOAD_LAT(2)) dut2 (.clk(clk), .rst(rst), .instr_in(instr_in),
    .instr_valid(instr_valid), .flush(flush), .pc_en(pc_en2), .instr_sel(sel2),
    .instr_out(out2), .stall_cnt(cnt2));
  hazard_issue_ctrl #(.CNT_W(4)) dut3 (.clk(clk), .rst(rst), .instr_in(instr_in),
    .instr_valid(instr_valid), .flush(flush), .pc_en(pc_en3), .instr_sel(sel3),
    .instr_out(out3), .stall_cnt(cnt3));
  hazard_issue_ctrl #(.BR_BUBBLES(0)) dut4 (.clk(clk), .rst(rst), .instr_in(instr_in),
    .instr_valid(instr_valid), .flush(flush), .pc_en(pc_en4), .instr_sel(sel4),
    .instr_out(out4), .stall_cnt(cnt4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic [15:0] ins, input logic v, input logic f);
    @(negedge clk);
    rst = 1'b0;
    instr_in = ins;
    instr_valid = v;
    flush = f;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    flush = 1'b0;
    instr_in = 16'h0;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_pc_en", 32'(pc_en1), 32'd1);
    chk("rst_sel", 32'(sel1), 32'd1);
    chk("rst_cnt", 32'(cnt1), 32'd0);

    // T1: LW r3 ; ADD r5,r3,r1 with LOAD_LAT=1
    drive(16'h8300, 1, 0);
    chk("t1_lw_issue", {pc_en1, sel1, out1}, {1'b1, 1'b0, 16'h8300});
    drive(16'h0531, 1, 0);
    chk("t1_stall", {pc_en1, sel1, out1}, {1'b0, 1'b1, 16'h7000});
    drive(16'h0531, 1, 0);
    chk("t1_add_issue", {pc_en1, sel1, out1}, {1'b1, 1'b0, 16'h0531});

    // T2: LOAD_LAT=2, LW r3 ; SUB r4,r2,r1 ; ADD r5,r3,r2
    do_reset();
    drive(16'h8300, 1, 0);
    chk("t2_lw", 32'(sel2), 32'd0);
    drive(16'h1421, 1, 0);
    chk("t2_sub", 32'(sel2), 32'd0);
    drive(16'h0532, 1, 0);
    chk("t2_bubble", {pc_en2, sel2, out2}, {1'b0, 1'b1, 16'h7000});
    drive(16'h0532, 1, 0);
    chk("t2_add", {pc_en2, sel2, out2}, {1'b1, 1'b0, 16'h0532});
    drive(16'h8000, 1, 0);
    drive(16'h0500, 1, 0);
    chk("t2_r0_nostall", {pc_en2, sel2}, {1'b1, 1'b0});

    // T3: ADD then control, BR_BUBBLES=2 (dut1) and 0 (dut4)
    do_reset();
    drive(16'h0123, 1, 0);
    chk("t3_add", 32'(sel1), 32'd0);
    drive(16'hD000, 1, 0);
    chk("t3_flag", {pc_en1, sel1}, {1'b0, 1'b1});
    chk("t3_flag_bb0", {pc_en4, sel4}, {1'b0, 1'b1});
    drive(16'hD000, 1, 0);
    chk("t3_br", {pc_en1, sel1, out1}, {1'b1, 1'b0, 16'hD000});
    drive(16'h2000, 1, 0);
    chk("t3_shadow1", {pc_en1, sel1, out1}, {1'b0, 1'b1, 16'h7000});
    chk("t3_noshadow_bb0", {pc_en4, sel4}, {1'b1, 1'b0});
    drive(16'h2000, 1, 0);
    chk("t3_shadow2", {pc_en1, sel1}, {1'b0, 1'b1});
    drive(16'h2000, 1, 0);
    chk("t3_resume", {pc_en1, sel1}, {1'b1, 1'b0});
    chk("t3_cnt", 32'(cnt1), 32'd3);

    // T4: EXEC ; control (exempt) ; control (shadowed)
    do_reset();
    drive(16'hC000, 1, 0);
    chk("t4_exec", 32'(sel1), 32'd0);
    drive(16'hD000, 1, 0);
    chk("t4_exempt", {pc_en1, sel1}, {1'b1, 1'b0});
    drive(16'hD100, 1, 0);
    chk("t4_ctrl2", {pc_en1, sel1}, {1'b1, 1'b0});
    drive(16'h2000, 1, 0);
    chk("t4_sh1", {pc_en1, sel1}, {1'b0, 1'b1});
    drive(16'h2000, 1, 0);
    chk("t4_sh2", {pc_en1, sel1}, {1'b0, 1'b1});
    drive(16'h2000, 1, 0);
    chk("t4_after", {pc_en1, sel1}, {1'b1, 1'b0});

    // T5: flush during 2nd shadow bubble
    do_reset();
    drive(16'hD000, 1, 0);
    drive(16'h0531, 1, 0);
    chk("t5_sh1", {pc_en1, sel1}, {1'b0, 1'b1});
    drive(16'h0531, 1, 1);
    chk("t5_flush", {pc_en1, sel1, out1}, {1'b1, 1'b1, 16'h7000});
    drive(16'h0531, 1, 0);
    chk("t5_issue", {pc_en1, sel1, out1}, {1'b1, 1'b0, 16'h0531});
    // flush empties the scoreboard and drops a load arriving with it (LOAD_LAT=2)
    do_reset();
    drive(16'h8300, 1, 0);
    drive(16'h8400, 1, 1);
    chk("t5_flush_ld", {pc_en2, sel2}, {1'b1, 1'b1});
    drive(16'h0534, 1, 0);
    chk("t5_sb_empty", {pc_en2, sel2, out2}, {1'b1, 1'b0, 16'h0534});

    // T6: async reset mid load-stall
    do_reset();
    drive(16'h0000, 0, 0);
    drive(16'h0000, 0, 0);
    drive(16'h8300, 1, 0);
    drive(16'h0531, 1, 0);
    chk("t6_stall", {pc_en1, sel1}, {1'b0, 1'b1});
    chk("t6_cnt_pre", 32'(cnt1), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_out", {pc_en1, sel1}, {1'b1, 1'b0});
    chk("t6_rst_cnt", 32'(cnt1), 32'd0);

    // Saturation with CNT_W=4
    do_reset();
    for (int i = 0; i < 21; i++) drive(16'h0000, 0, 0);
    chk("t6_sat4", 32'(cnt3), 32'd15);
    chk("t6_cnt16", 32'(cnt1), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
